regfile_sb: RTL

- Parametrised successor to the general-purpose register file. Configurable width, depth, and hardwired-zero register.
- Adds same-cycle write-to-read bypass and a per-register busy scoreboard for multi-cycle producers (loads, multiply).
- Sits between decode and execute. Decode reads operands and busy flags. Writeback drives the write port.

---
 rtl/regfile_sb.sv | 90 +++++++++
 1 files changed

// File: rtl/regfile_sb.sv
// Parametrised register file with same-cycle write bypass and a per-register
// busy scoreboard that tracks multi-cycle producers between issue and writeback.
module regfile_sb #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  output logic [WIDTH-1:0]  read_data1,
  output logic [WIDTH-1:0]  read_data2,
  output logic              busy1,
  output logic              busy2,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic              reg_write_flag,
  input  logic [WIDTH-1:0]  data,
  input  logic [ADDR_W-1:0] issue_reg,
  input  logic              issue_flag,
  output logic [ADDR_W:0]   pending_cnt
);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_next;
  logic [ADDR_W:0]  cnt_next;
  logic             wr_ok;
  logic             iss_ok;
  logic             hit1;
  logic             hit2;

  // An address is usable if it exists and is not the hardwired zero register.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (int'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign wr_ok  = reg_write_flag && addr_ok(write_reg);
  assign iss_ok = issue_flag && addr_ok(issue_reg);
  assign hit1   = (BYPASS != 0) && wr_ok && (write_reg == read_reg1);
  assign hit2   = (BYPASS != 0) && wr_ok && (write_reg == read_reg2);

  // Issue is applied after writeback so a new producer supersedes a completing one.
  always_comb begin
    busy_next = busy;
    if (wr_ok)
      busy_next[write_reg] = 1'b0;
    if (iss_ok)
      busy_next[issue_reg] = 1'b1;
  end

  always_comb begin
    cnt_next = '0;
    for (int i = 0; i < DEPTH; i++)
      cnt_next = cnt_next + {{ADDR_W{1'b0}}, busy_next[i]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
      busy        <= '0;
      pending_cnt <= '0;
    end else begin
      if (wr_ok)
        regs[write_reg] <= data;
      busy        <= busy_next;
      pending_cnt <= cnt_next;
    end
  end

  // Forwarded write data also means the producer is done, so busy is masked.
  always_comb begin
    read_data1 = '0;
    busy1      = 1'b0;
    read_data2 = '0;
    busy2      = 1'b0;
    if (addr_ok(read_reg1)) begin
      read_data1 = hit1 ? data : regs[read_reg1];
      busy1      = busy[read_reg1] && !hit1;
    end
    if (addr_ok(read_reg2)) begin
      read_data2 = hit2 ? data : regs[read_reg2];
      busy2      = busy[read_reg2] && !hit2;
    end
  end

endmodule
